// File: rtl/sysbus_pkg.sv
// Shared system-bus definitions: tag encoding, special tags and the
// memory responder state encoding. Used by the responder and the caches.
package sysbus_pkg;

  localparam int SYSBUS_TAG_W       = 13;
  localparam int SYSBUS_TAG_DIR_BIT = 12;
  localparam int SYSBUS_TAG_DEV_HI  = 11;
  localparam int SYSBUS_TAG_DEV_LO  = 8;
  localparam int SYSBUS_BEATS       = 8;

  localparam logic       SYSBUS_READ   = 1'b1;
  localparam logic       SYSBUS_WRITE  = 1'b0;
  localparam logic [3:0] SYSBUS_MEMORY = 4'h1;

  // Invalidate broadcasts carry this tag instead of an echoed request tag.
  localparam logic [SYSBUS_TAG_W-1:0] SYSBUS_INV_TAG = 13'h0800;

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    RD_WAIT,
    RD_BURST,
    WR_DATA,
    INV
  } resp_state_e;

  function automatic logic tag_is_memory(input logic [SYSBUS_TAG_W-1:0] tag);
    return tag[SYSBUS_TAG_DEV_HI:SYSBUS_TAG_DEV_LO] == SYSBUS_MEMORY;
  endfunction

  function automatic logic tag_is_read(input logic [SYSBUS_TAG_W-1:0] tag);
    return tag[SYSBUS_TAG_DIR_BIT] == SYSBUS_READ;
  endfunction

endpackage

// File: rtl/sysbus_line_ram.sv
// Line-organised backing store: one full cache line per access, single
// port, registered read data that holds until the next read.
module sysbus_line_ram #(
  parameter int LINES     = 1024,
  parameter int LINE_BITS = 512,
  parameter int IDX_W     = $clog2(LINES)
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [IDX_W-1:0]     addr,
  input  logic [LINE_BITS-1:0] wdata,
  output logic [LINE_BITS-1:0] rdata
);

  logic [LINE_BITS-1:0] mem [LINES];

  // Single port: a write or a registered read, never both in one cycle.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/sysbus_mem_responder.sv
// Memory-side system bus responder: accepts line reads and writes from one
// initiator, returns critical-word-first read bursts, absorbs write bursts
// and broadcasts invalidates on behalf of an external snoop source.
module sysbus_mem_responder
  import sysbus_pkg::*;
#(
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BUS_DATA_WIDTH = 64,
  parameter int MEM_LINES      = 1024,
  parameter int RD_LATENCY     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack,
  input  logic                      inv_req,
  input  logic [BUS_DATA_WIDTH-1:0] inv_addr,
  output logic                      inv_busy
);

  localparam int LINE_BITS = BUS_DATA_WIDTH * SYSBUS_BEATS;
  localparam int BUF_BITS  = LINE_BITS - BUS_DATA_WIDTH;
  localparam int IDX_W     = $clog2(MEM_LINES);
  localparam int WAIT_W    = $clog2(RD_LATENCY + 1);

  // RD_WAIT lasts RD_LATENCY-1 cycles, so the counter starts two below it.
  localparam logic [WAIT_W-1:0] WAIT_INIT =
    WAIT_W'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);

  resp_state_e state;

  logic [IDX_W-1:0]  line_q;
  logic [2:0]        start_beat_q;
  logic [BUS_TAG_WIDTH-1:0] tag_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [2:0]        beat;
  logic [2:0]        xfer_cnt;
  logic [2:0]        beat_next;
  logic [2:0]        word_sel;

  logic [BUF_BITS-1:0]       wr_buf;
  logic [BUS_DATA_WIDTH-1:7] inv_line_hi;
  logic                      inv_bit6;
  logic [BUS_DATA_WIDTH-7:0] inv_line_q;

  logic                 accept;
  logic                 wr_last;
  logic                 start_burst;
  logic                 ram_en;
  logic                 ram_we;
  logic [IDX_W-1:0]     ram_addr;
  logic [LINE_BITS-1:0] ram_wdata;
  logic [LINE_BITS-1:0] ram_q;
  logic [BUS_DATA_WIDTH-1:0] ram_words [SYSBUS_BEATS];
  logic [BUS_DATA_WIDTH-1:0] sel_word;
  logic                 unused_inv_low;

  assign unused_inv_low = ^{inv_addr[5:0], inv_line_hi, inv_bit6};
  assign inv_line_hi    = inv_addr[BUS_DATA_WIDTH-1:7];
  assign inv_bit6       = inv_addr[6];

  // A request is taken only from IDLE, only for memory, and only when no
  // invalidate is waiting to go out first.
  assign accept  = (state == IDLE) && !inv_busy && bus_reqcyc &&
                   tag_is_memory(bus_reqtag);
  assign wr_last = (state == WR_DATA) && bus_reqcyc && (xfer_cnt == 3'd7);

  assign start_burst = ((state == ACK) && (RD_LATENCY == 1)) ||
                       ((state == RD_WAIT) && (wait_cnt == '0));

  // The line is read on acceptance so its data is ready by the first beat;
  // the commit uses the eighth beat straight off the bus.
  assign ram_en    = (accept || wr_last) && !reset;
  assign ram_we    = wr_last;
  assign ram_addr  = (state == WR_DATA) ? line_q : bus_req[6+IDX_W-1:6];
  assign ram_wdata = {bus_req, wr_buf};

  assign beat_next = beat + 3'd1;
  assign word_sel  = (state == RD_BURST) ? beat_next : start_beat_q;
  assign sel_word  = ram_words[word_sel];

  sysbus_line_ram #(
    .LINES     (MEM_LINES),
    .LINE_BITS (LINE_BITS),
    .IDX_W     (IDX_W)
  ) u_line_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  // Split the registered line into beat-sized words for the read mux.
  always_comb begin
    for (int i = 0; i < SYSBUS_BEATS; i++) begin
      ram_words[i] = ram_q[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
    end
  end

  // Collect the first seven write beats; the eighth goes directly to RAM.
  always_ff @(posedge clk) begin
    if (state == WR_DATA && bus_reqcyc) begin
      for (int i = 0; i < SYSBUS_BEATS - 1; i++) begin
        if (xfer_cnt == 3'(i)) begin
          wr_buf[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= bus_req;
        end
      end
    end
  end

  // Invalidate slot: latch one request, hold it until the INV cycle drains it.
  always_ff @(posedge clk) begin
    if (reset) begin
      inv_busy   <= 1'b0;
      inv_line_q <= '0;
    end else if (state == INV) begin
      inv_busy <= 1'b0;
    end else if (inv_req && !inv_busy) begin
      inv_busy   <= 1'b1;
      inv_line_q <= inv_addr[BUS_DATA_WIDTH-1:6];
    end
  end

  // Responder FSM with all bus outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bus_reqack   <= 1'b0;
      bus_respcyc  <= 1'b0;
      bus_resp     <= '0;
      bus_resptag  <= '0;
      line_q       <= '0;
      start_beat_q <= '0;
      tag_q        <= '0;
      wait_cnt     <= '0;
      beat         <= '0;
      xfer_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inv_busy) begin
            state       <= INV;
            bus_respcyc <= 1'b1;
            bus_resptag <= BUS_TAG_WIDTH'(SYSBUS_INV_TAG);
            bus_resp    <= {inv_line_q, 6'b0};
          end else if (accept) begin
            state        <= ACK;
            bus_reqack   <= 1'b1;
            line_q       <= bus_req[6+IDX_W-1:6];
            start_beat_q <= bus_req[5:3];
            tag_q        <= bus_reqtag;
            xfer_cnt     <= '0;
          end
        end

        ACK: begin
          bus_reqack <= 1'b0;
          if (!tag_is_read(tag_q)) begin
            state <= WR_DATA;
          end else if (start_burst) begin
            state       <= RD_BURST;
            beat        <= start_beat_q;
            bus_resp    <= sel_word;
            bus_respcyc <= 1'b1;
            bus_resptag <= tag_q;
            xfer_cnt    <= '0;
          end else begin
            state    <= RD_WAIT;
            wait_cnt <= WAIT_INIT;
          end
        end

        RD_WAIT: begin
          if (start_burst) begin
            state       <= RD_BURST;
            beat        <= start_beat_q;
            bus_resp    <= sel_word;
            bus_respcyc <= 1'b1;
            bus_resptag <= tag_q;
            xfer_cnt    <= '0;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        RD_BURST: begin
          if (bus_respack) begin
            if (xfer_cnt == 3'd7) begin
              state       <= IDLE;
              bus_respcyc <= 1'b0;
              bus_resp    <= '0;
              bus_resptag <= '0;
            end else begin
              xfer_cnt <= xfer_cnt + 3'd1;
              beat     <= beat_next;
              bus_resp <= sel_word;
            end
          end
        end

        WR_DATA: begin
          if (bus_reqcyc) begin
            if (xfer_cnt == 3'd7) begin
              state <= IDLE;
            end else begin
              xfer_cnt <= xfer_cnt + 3'd1;
            end
          end
        end

        INV: begin
          state       <= IDLE;
          bus_respcyc <= 1'b0;
          bus_resp    <= '0;
          bus_resptag <= '0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
